// File: rtl/dslope_adc_pkg.sv
// -----------------------------------------------------------------------------
// dslope_adc_pkg
//   Shared definitions for the dual-slope ADC sequencer: the conversion state
//   encoding, default parameter values and a small elaboration-time helper.
//   No ports.
// -----------------------------------------------------------------------------
package dslope_adc_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_RDY  = 3'd1,
    DISCHARGE = 3'd2,
    INTEGRATE = 3'd3,
    DEINT     = 3'd4,
    DONE      = 3'd5
  } dsadc_state_e;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_CNT_W      = 12;
  localparam int DEF_INT_CYCLES = 1024;
  localparam int DEF_DIS_CYCLES = 16;

  // Larger of two cycle counts; sizes the shared phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dslope_sync2.sv
// -----------------------------------------------------------------------------
// dslope_sync2
//   Two-flop synchroniser bringing the asynchronous comparator output into the
//   clk_i domain. Resets to 0.
//   Ports:
//     clk_i    in  clock
//     rst_n_i  in  asynchronous active-low reset
//     d        in  asynchronous input
//     q        out synchronised output (two-cycle latency)
// -----------------------------------------------------------------------------
module dslope_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value; with blocking '=' d would race straight through both
  // stages in one cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dslope_adc_seq.sv
// -----------------------------------------------------------------------------
// dslope_adc_seq
//   Multi-channel dual-slope ADC sequencer. On trigger it converts either all
//   channels 0..N_CH-1 or one requested channel. Each conversion runs
//   WAIT_RDY -> DISCHARGE (DIS_CYCLES) -> INTEGRATE (INT_CYCLES) -> DEINT
//   (counts cycles while the synchronised comparator is high) -> DONE
//   (one-cycle result strobe). The last channel of a scan sets a sticky
//   interrupt.
//
//   Optional feature macro: DSADC_TIMEOUT_EN
//     When defined, DEINT ends once the count has saturated at all-ones; the
//     result is all-ones and the extra output ovf_o pulses with result_valid_o.
//     When undefined, the count wraps and DEINT waits for the comparator.
//
//   Ports:
//     clk_i, rst_n_i       clock, asynchronous active-low reset
//     trigger_i            start a scan (accepted in IDLE only)
//     scan_all_i           1: scan all channels, 0: convert ch_req_i only
//     ch_req_i             channel for single-channel conversion
//     analog_ready_i       front end settled (checked in WAIT_RDY only)
//     comp_i               asynchronous comparator, 1 = above threshold
//     interrupt_clear_i    clears interrupt_o (a simultaneous set wins)
//     ch_sel_o             analog mux select
//     discharge_o          integrator discharge switch
//     integrate_o          input connected to integrator
//     deintegrate_o        reference connected to integrator
//     busy_o               sequencer not idle
//     result_o/result_ch_o last count and its channel
//     result_valid_o       one-cycle result strobe
//     interrupt_o          sticky scan-complete flag
//     ovf_o                (DSADC_TIMEOUT_EN only) de-integrate timeout strobe
// -----------------------------------------------------------------------------
module dslope_adc_seq
  import dslope_adc_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int INT_CYCLES = DEF_INT_CYCLES,
  parameter int DIS_CYCLES = DEF_DIS_CYCLES,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             trigger_i,
  input  logic             scan_all_i,
  input  logic [CH_W-1:0]  ch_req_i,
  input  logic             analog_ready_i,
  input  logic             comp_i,
  input  logic             interrupt_clear_i,
  output logic [CH_W-1:0]  ch_sel_o,
  output logic             discharge_o,
  output logic             integrate_o,
  output logic             deintegrate_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic [CH_W-1:0]  result_ch_o,
  output logic             result_valid_o,
  output logic             interrupt_o
`ifdef DSADC_TIMEOUT_EN
  ,
  output logic             ovf_o
`endif
);

  // One timer serves both fixed-length phases; it counts 0 .. length-1.
  localparam int TMR_MAX = max_int(INT_CYCLES, DIS_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] DIS_LAST = TMR_W'(DIS_CYCLES - 1);
  localparam logic [TMR_W-1:0] INT_LAST = TMR_W'(INT_CYCLES - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  dsadc_state_e     r_state,     w_state_nxt;
  logic [TMR_W-1:0] r_timer,     w_timer_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [CH_W-1:0]  r_ch,        w_ch_nxt;
  logic             r_scan_all,  w_scan_all_nxt;
  logic [CNT_W-1:0] r_result,    w_result_nxt;
  logic [CH_W-1:0]  r_result_ch, w_result_ch_nxt;
  logic             r_irq,       w_irq_nxt;
  logic             w_irq_set;
  logic             r_dis, r_int, r_deint, r_busy, r_valid;
  logic             w_comp_s;
`ifdef DSADC_TIMEOUT_EN
  logic             r_ovf, w_ovf_nxt;
`endif

  dslope_sync2 u_comp_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d       (comp_i),
    .q       (w_comp_s)
  );

  // NOTE: every signal written here gets a default before the case; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_cnt_nxt       = r_cnt;
    w_ch_nxt        = r_ch;
    w_scan_all_nxt  = r_scan_all;
    w_result_nxt    = r_result;
    w_result_ch_nxt = r_result_ch;
    w_irq_set       = 1'b0;
`ifdef DSADC_TIMEOUT_EN
    w_ovf_nxt       = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (trigger_i) begin
          w_ch_nxt       = scan_all_i ? '0 : ch_req_i;
          w_scan_all_nxt = scan_all_i;
          w_state_nxt    = WAIT_RDY;
        end
      end

      WAIT_RDY: begin
        w_timer_nxt = '0;
        if (analog_ready_i) w_state_nxt = DISCHARGE;
      end

      DISCHARGE: begin
        if (r_timer == DIS_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = INTEGRATE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      INTEGRATE: begin
        if (r_timer == INT_LAST) begin
          w_timer_nxt = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = DEINT;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      DEINT: begin
        if (!w_comp_s) begin
          w_result_nxt    = r_cnt;
          w_result_ch_nxt = r_ch;
          w_state_nxt     = DONE;
`ifdef DSADC_TIMEOUT_EN
        end else if (&r_cnt) begin
          // Comparator still high with the count saturated: give up.
          w_result_nxt    = '1;
          w_result_ch_nxt = r_ch;
          w_ovf_nxt       = 1'b1;
          w_state_nxt     = DONE;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      DONE: begin
        if (r_scan_all && (r_ch != CH_LAST)) begin
          w_ch_nxt    = r_ch + CH_W'(1);
          w_state_nxt = WAIT_RDY;
        end else begin
          w_irq_set   = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    // Set has priority over a coincident clear.
    w_irq_nxt = w_irq_set | (r_irq & ~interrupt_clear_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_scan_all  <= 1'b0;
      r_result    <= '0;
      r_result_ch <= '0;
      r_irq       <= 1'b0;
      r_dis       <= 1'b0;
      r_int       <= 1'b0;
      r_deint     <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ch        <= w_ch_nxt;
      r_scan_all  <= w_scan_all_nxt;
      r_result    <= w_result_nxt;
      r_result_ch <= w_result_ch_nxt;
      r_irq       <= w_irq_nxt;
      // Switch controls are decoded from the next state and registered, so
      // they change glitch-free exactly on state entry and are one-hot.
      r_dis       <= (w_state_nxt == DISCHARGE);
      r_int       <= (w_state_nxt == INTEGRATE);
      r_deint     <= (w_state_nxt == DEINT);
      r_busy      <= (w_state_nxt != IDLE);
      r_valid     <= (w_state_nxt == DONE);
    end
  end

`ifdef DSADC_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_ovf <= 1'b0;
    else          r_ovf <= w_ovf_nxt;
  end

  assign ovf_o = r_ovf;
`endif

  assign ch_sel_o       = r_ch;
  assign discharge_o    = r_dis;
  assign integrate_o    = r_int;
  assign deintegrate_o  = r_deint;
  assign busy_o         = r_busy;
  assign result_o       = r_result;
  assign result_ch_o    = r_result_ch;
  assign result_valid_o = r_valid;
  assign interrupt_o    = r_irq;

endmodule

// File: tb/tb_dslope_adc_seq.sv
// -----------------------------------------------------------------------------
// tb_dslope_adc_seq
//   Self-checking bench for dslope_adc_seq (default build; ovf_o is connected
//   and checked only when DSADC_TIMEOUT_EN is defined).
//   The stimulus holds comp_i high and drops it K clocks after de-integration
//   starts. The comparator passes a two-stage synchroniser, so the sequencer
//   still sees it high for SYNC_LAT more de-integrate cycles: the expected
//   count is K + SYNC_LAT.
// -----------------------------------------------------------------------------
module tb_dslope_adc_seq;

  localparam int N_CH       = 4;
  localparam int CNT_W      = 12;
  localparam int INT_CYCLES = 100;
  localparam int DIS_CYCLES = 5;
  localparam int CH_W       = 2;
  localparam int SYNC_LAT   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             trigger_i, scan_all_i, analog_ready_i, comp_i, interrupt_clear_i;
  logic [CH_W-1:0]  ch_req_i;
  logic [CH_W-1:0]  ch_sel_o, result_ch_o;
  logic             discharge_o, integrate_o, deintegrate_o, busy_o;
  logic             result_valid_o, interrupt_o;
  logic [CNT_W-1:0] result_o;
`ifdef DSADC_TIMEOUT_EN
  logic             ovf_o;
`endif

  dslope_adc_seq #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .INT_CYCLES (INT_CYCLES),
    .DIS_CYCLES (DIS_CYCLES)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .trigger_i         (trigger_i),
    .scan_all_i        (scan_all_i),
    .ch_req_i          (ch_req_i),
    .analog_ready_i    (analog_ready_i),
    .comp_i            (comp_i),
    .interrupt_clear_i (interrupt_clear_i),
    .ch_sel_o          (ch_sel_o),
    .discharge_o       (discharge_o),
    .integrate_o       (integrate_o),
    .deintegrate_o     (deintegrate_o),
    .busy_o            (busy_o),
    .result_o          (result_o),
    .result_ch_o       (result_ch_o),
    .result_valid_o    (result_valid_o),
    .interrupt_o       (interrupt_o)
`ifdef DSADC_TIMEOUT_EN
    ,
    .ovf_o             (ovf_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {10'd0, ch_sel_o, discharge_o, integrate_o, deintegrate_o, busy_o,
            result_o, result_ch_o, result_valid_o, interrupt_o};
  endfunction

  // ---------------------------------------------------------------- model ---
  typedef struct {
    int ch;
    int val;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_strobes  = 0;
  bit   m_irq      = 1'b0;
  bit   final_prev = 1'b0;
  bit   pe_clear   = 1'b0;
  bit   prev_dis   = 1'b0;
  bit   prev_int   = 1'b0;
  bit   prev_valid = 1'b0;
  int   dis_run    = 0;
  int   int_run    = 0;

  // Input value the DUT sees at each rising edge.
  always @(posedge clk) pe_clear = interrupt_clear_i;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_irq      = 1'b0;
      final_prev = 1'b0;
      prev_dis   = 1'b0;
      prev_int   = 1'b0;
      prev_valid = 1'b0;
      dis_run    = 0;
      int_run    = 0;
      exp_q.delete();
    end else begin
      // Interrupt: set by the cycle after the final channel's strobe, else
      // cleared by interrupt_clear_i, else held.
      if (final_prev)    m_irq = 1'b1;
      else if (pe_clear) m_irq = 1'b0;
      final_prev = 1'b0;
      check("irq", interrupt_o, m_irq);

      check("phase_onehot",
            (int'(discharge_o) + int'(integrate_o) + int'(deintegrate_o)) > 1, 0);
      if (discharge_o || integrate_o || deintegrate_o) check("busy_in_phase", busy_o, 1);

      if (discharge_o) dis_run++;
      else if (prev_dis) begin
        check("discharge_len", dis_run, DIS_CYCLES);
        dis_run = 0;
      end
      if (integrate_o) int_run++;
      else if (prev_int) begin
        check("integrate_len", int_run, INT_CYCLES);
        int_run = 0;
      end

      if (prev_valid) check("strobe_width", result_valid_o, 0);
      if (result_valid_o) begin
        n_strobes++;
        check("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_ch", result_ch_o, e.ch);
          check("result", result_o, e.val);
          final_prev = e.last;
        end
`ifdef DSADC_TIMEOUT_EN
        check("ovf", ovf_o, 0);
`endif
      end

      prev_dis   = discharge_o;
      prev_int   = integrate_o;
      prev_valid = result_valid_o;
    end
  end

  // ----------------------------------------------------------- stimulus ---
  function automatic bit sig(input int which);
    case (which)
      0:       return deintegrate_o;
      1:       return integrate_o;
      default: return busy_o;
    endcase
  endfunction

  // Wait (sampling on falling edges) until the chosen output reaches lvl.
  task automatic wait_for(input int which, input bit lvl, input int budget, input string nm);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (n < budget && !hit) begin
      @(negedge clk);
      if (sig(which) == lvl) hit = 1'b1;
      n++;
    end
    check({nm, "_timeout"}, hit, 1);
  endtask

  task automatic pulse_trigger(input bit all, input int ch);
    @(posedge clk);
    #1;
    trigger_i  = 1'b1;
    scan_all_i = all;
    ch_req_i   = CH_W'(ch);
    @(posedge clk);
    #1;
    trigger_i  = 1'b0;
  endtask

  // Returns on the falling edge of the DONE (strobe) cycle.
  task automatic run_channel(input int ch, input int k, input bit last);
    exp_t e;
    wait_for(0, 1'b1, 1000, "deint_rise");
    e.ch   = ch;
    e.val  = k + SYNC_LAT;
    e.last = last;
    exp_q.push_back(e);
    repeat (k) @(posedge clk);
    #1 comp_i = 1'b0;
    wait_for(0, 1'b0, k + 20, "deint_fall");
    #1 comp_i = 1'b1;
  endtask

  task automatic clear_irq();
    @(posedge clk);
    #1 interrupt_clear_i = 1'b1;
    @(posedge clk);
    #1 interrupt_clear_i = 1'b0;
    @(negedge clk);
    check("irq_cleared", interrupt_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ks[4];
    int s0;
    ks = '{10, 20, 30, 40};

    rst_n             = 1'b0;
    trigger_i         = 1'b0;
    scan_all_i        = 1'b0;
    ch_req_i          = '0;
    analog_ready_i    = 1'b1;
    comp_i            = 1'b1;
    interrupt_clear_i = 1'b0;

    #23;
    check("reset_outputs", all_outs(), 0);
    #4 rst_n = 1'b1;

    // 1: single channel 2, comparator drops 300 clocks into DEINT.
    pulse_trigger(1'b0, 2);
    run_channel(2, 300, 1'b1);
    check("t1_valid", result_valid_o, 1);
    check("t1_result", result_o, 302);
    check("t1_ch", result_ch_o, 2);
    @(negedge clk);
    check("t1_irq", interrupt_o, 1);
    check("t1_idle", busy_o, 0);
    clear_irq();

    // 2: full scan, four results in channel order, interrupt after ch3 only.
    pulse_trigger(1'b1, 3);
    for (int i = 0; i < N_CH; i++) begin
      run_channel(i, ks[i], i == N_CH - 1);
      check("t2_irq_at_strobe", interrupt_o, 0);
    end
    check("t2_last_result", result_o, 42);
    check("t2_last_ch", result_ch_o, 3);
    @(negedge clk);
    check("t2_irq", interrupt_o, 1);
    clear_irq();

    // 3: front end not ready for 50 cycles; ready dropping later is ignored.
    analog_ready_i = 1'b0;
    pulse_trigger(1'b0, 1);
    repeat (50) @(negedge clk);
    check("t3_busy_waiting", busy_o, 1);
    check("t3_no_discharge", discharge_o, 0);
    check("t3_ch_sel", ch_sel_o, 1);
    #1 analog_ready_i = 1'b1;
    wait_for(1, 1'b1, 50, "t3_integrate");
    #1 analog_ready_i = 1'b0;
    run_channel(1, 7, 1'b1);
    check("t3_result", result_o, 9);
    #1 analog_ready_i = 1'b1;
    clear_irq();

    // 4: triggers while busy are dropped; clear coincident with set loses.
    s0 = n_strobes;
    pulse_trigger(1'b0, 3);
    wait_for(1, 1'b1, 200, "t4_integrate");
    repeat (3) begin
      @(posedge clk);
      #1 trigger_i = 1'b1;
      scan_all_i   = 1'b1;
      @(posedge clk);
      #1 trigger_i = 1'b0;
    end
    scan_all_i = 1'b0;
    run_channel(3, 15, 1'b1);
    interrupt_clear_i = 1'b1;
    @(posedge clk);
    #1 interrupt_clear_i = 1'b0;
    @(negedge clk);
    check("t4_irq_set_wins", interrupt_o, 1);
    repeat (300) @(negedge clk);
    check("t4_no_extra_scan", busy_o, 0);
    check("t4_strobe_count", n_strobes - s0, 1);
    clear_irq();

    // 5: reset during INTEGRATE aborts; the next conversion is normal.
    s0 = n_strobes;
    pulse_trigger(1'b0, 0);
    wait_for(1, 1'b1, 200, "t5_integrate");
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("t5_no_strobe", n_strobes - s0, 0);
    pulse_trigger(1'b0, 3);
    run_channel(3, 5, 1'b1);
    check("t5_result", result_o, 7);
    check("t5_ch", result_ch_o, 3);

    repeat (5) @(negedge clk);
    check("expected_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
